// File: rtl/fme_pkg.sv
// rtl/fme_pkg.sv - shared state encoding and timing constants for the FME arbiter
package fme_pkg;

   typedef enum logic [2:0] {
      LIVRE        = 3'd0,
      DISPARO      = 3'd1,
      AGUARDA_DONE = 3'd2,
      SAIDA        = 3'd3,
      CONCLUI      = 3'd4
   } estado_t;

   localparam int FME_CICLOS_JOB        = 43;
   localparam int TIMEOUT_CICLOS_PADRAO = 127;

endpackage

// File: rtl/fme_arbitro_if.sv
// rtl/fme_arbitro_if.sv - requester/controller handshake bundle of the FME arbiter
interface fme_arbitro_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  id_ativo;
   logic             ocupado;
   logic             enable_fme;
   logic             done_fme;
   logic             reset_fme;
   logic             concluido;
   logic [ID_W-1:0]  concluido_id;
   logic             erro_timeout;

   // master is the arbiter itself; slave is the requester/controller side
   modport master (
      input  req, done_fme,
      output gnt, id_ativo, ocupado, enable_fme, reset_fme,
             concluido, concluido_id, erro_timeout
   );

   modport slave (
      output req, done_fme,
      input  gnt, id_ativo, ocupado, enable_fme, reset_fme,
             concluido, concluido_id, erro_timeout
   );
endinterface

// File: rtl/fme_rr_seletor.sv
// rtl/fme_rr_seletor.sv - combinational round-robin pick: first set req after ultimo, with wrap
module fme_rr_seletor
   import fme_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ultimo,
   output logic [N_REQ-1:0] vencedor,
   output logic [ID_W-1:0]  vencedor_id,
   output logic             algum
);

   int idx;

   always_comb begin
      vencedor_id = '0;
      vencedor    = '0;
      idx         = 0;
      algum       = |req;
      // scan from the farthest candidate back to ultimo+1 so the nearest one is written last
      for (int k = N_REQ; k >= 1; k--) begin
         idx = (int'(ultimo) + k) % N_REQ;
         if (req[idx]) begin
            vencedor_id = ID_W'(idx);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         vencedor[i] = algum && (vencedor_id == ID_W'(i));
      end
   end

endmodule

// File: rtl/fme_arbitro.sv
// rtl/fme_arbitro.sv - round-robin scheduler sharing one FME interpolator; watchdog under FME_ARB_TIMEOUT_EN
module fme_arbitro
   import fme_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int ID_W           = $clog2(N_REQ),
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
   parameter int CNT_W          = $clog2(TIMEOUT_CICLOS + 1)
) (
   input  logic          clock,
   input  logic          reset,
   fme_arbitro_if.master bus
);

   estado_t          estado;
   logic [ID_W-1:0]  ultimo;
   logic [N_REQ-1:0] gnt_r;
   logic [ID_W-1:0]  id_ativo_r;
   logic             ocupado_r;
   logic             enable_r;
   logic             reset_fme_r;
   logic             concluido_r;
   logic [ID_W-1:0]  concluido_id_r;
   logic             erro_r;

   logic [N_REQ-1:0] vencedor;
   logic [ID_W-1:0]  vencedor_id;
   logic             algum;

   fme_rr_seletor #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_seletor (
      .req         (bus.req),
      .ultimo      (ultimo),
      .vencedor    (vencedor),
      .vencedor_id (vencedor_id),
      .algum       (algum)
   );

`ifdef FME_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] watchdog;
   logic             estouro;
   // fires on the edge where the count would reach TIMEOUT_CICLOS
   assign estouro = (watchdog == CNT_W'(TIMEOUT_CICLOS - 1));
`else
   // watchdog compiled out: the job never expires
   wire estouro = (CNT_W == 0);
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado         <= LIVRE;
         ultimo         <= ID_W'(N_REQ - 1);
         gnt_r          <= '0;
         id_ativo_r     <= '0;
         ocupado_r      <= 1'b0;
         enable_r       <= 1'b0;
         reset_fme_r    <= 1'b0;
         concluido_r    <= 1'b0;
         concluido_id_r <= '0;
         erro_r         <= 1'b0;
`ifdef FME_ARB_TIMEOUT_EN
         watchdog       <= '0;
`endif
      end else begin
         enable_r    <= 1'b0;
         reset_fme_r <= 1'b0;
         concluido_r <= 1'b0;
         erro_r      <= 1'b0;
`ifdef FME_ARB_TIMEOUT_EN
         if (estado == AGUARDA_DONE || estado == SAIDA) begin
            watchdog <= watchdog + 1'b1;
         end
`endif
         case (estado)
            LIVRE: begin
               if (algum) begin
                  gnt_r      <= vencedor;
                  id_ativo_r <= vencedor_id;
                  ocupado_r  <= 1'b1;
                  estado     <= DISPARO;
               end
            end
            DISPARO: begin
               enable_r <= 1'b1;
`ifdef FME_ARB_TIMEOUT_EN
               watchdog <= '0;
`endif
               estado   <= AGUARDA_DONE;
            end
            AGUARDA_DONE: begin
               if (bus.done_fme) begin
                  estado <= SAIDA;
               end else if (estouro) begin
                  reset_fme_r    <= 1'b1;
                  erro_r         <= 1'b1;
                  concluido_r    <= 1'b1;
                  concluido_id_r <= id_ativo_r;
                  estado         <= CONCLUI;
               end
            end
            SAIDA: begin
               // a falling done on the timeout edge still counts as a clean finish
               if (!bus.done_fme) begin
                  concluido_r    <= 1'b1;
                  concluido_id_r <= id_ativo_r;
                  estado         <= CONCLUI;
               end else if (estouro) begin
                  reset_fme_r    <= 1'b1;
                  erro_r         <= 1'b1;
                  concluido_r    <= 1'b1;
                  concluido_id_r <= id_ativo_r;
                  estado         <= CONCLUI;
               end
            end
            CONCLUI: begin
               gnt_r     <= '0;
               ocupado_r <= 1'b0;
               ultimo    <= id_ativo_r;
               estado    <= LIVRE;
            end
            default: begin
               estado <= LIVRE;
            end
         endcase
      end
   end

   assign bus.gnt          = gnt_r;
   assign bus.id_ativo     = id_ativo_r;
   assign bus.ocupado      = ocupado_r;
   assign bus.enable_fme   = enable_r;
   assign bus.concluido    = concluido_r;
   assign bus.concluido_id = concluido_id_r;
`ifdef FME_ARB_TIMEOUT_EN
   assign bus.reset_fme    = reset_fme_r;
   assign bus.erro_timeout = erro_r;
`else
   assign bus.reset_fme    = 1'b0;
   assign bus.erro_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fme_arbitro.sv
// tb/tb_fme_arbitro.sv - directed and randomized bench for fme_arbitro with a round-robin reference model
module tb_fme_arbitro;
   import fme_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;

   logic clock = 1'b0;
   logic reset;

   fme_arbitro_if #(.N_REQ(N), .ID_W(IW)) bus ();

   fme_arbitro #(.N_REQ(N), .ID_W(IW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;
   int ultimo_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // reference: nearest requesting index after the last served one, wrapping
   function automatic int pick(input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         if (r[(ultimo_m + k) % N]) return (ultimo_m + k) % N;
      end
      return -1;
   endfunction

   task automatic check_idle(input string tg);
      check({tg, " gnt"}, bus.gnt, 0);
      check({tg, " ocupado"}, bus.ocupado, 0);
      check({tg, " id_ativo"}, bus.id_ativo, 0);
      check({tg, " enable"}, bus.enable_fme, 0);
      check({tg, " concluido"}, bus.concluido, 0);
      check({tg, " reset_fme"}, bus.reset_fme, 0);
      check({tg, " erro"}, bus.erro_timeout, 0);
   endtask

   task automatic run_job(input logic [N-1:0] r, input int dlen, input bit drop, input string tg);
      int w;
      w = pick(r);
      bus.req = r;
      step();
      check({tg, " gnt"}, bus.gnt, 32'd1 << w);
      check({tg, " id_ativo"}, bus.id_ativo, w);
      check({tg, " ocupado"}, bus.ocupado, 1);
      check({tg, " enable early"}, bus.enable_fme, 0);
      step();
      check({tg, " enable"}, bus.enable_fme, 1);
      if (drop) bus.req = '0;
      step();
      check({tg, " enable width"}, bus.enable_fme, 0);
      bus.done_fme = 1'b1;
      for (int i = 0; i < dlen; i++) begin
         step();
         check({tg, " concluido early"}, bus.concluido, 0);
      end
      bus.done_fme = 1'b0;
      step();
      check({tg, " concluido"}, bus.concluido, 1);
      check({tg, " concluido_id"}, bus.concluido_id, w);
      check({tg, " erro"}, bus.erro_timeout, 0);
      check({tg, " gnt held"}, bus.gnt, 32'd1 << w);
      step();
      check({tg, " concluido width"}, bus.concluido, 0);
      check({tg, " gnt clear"}, bus.gnt, 0);
      check({tg, " ocupado clear"}, bus.ocupado, 0);
      ultimo_m = w;
   endtask

   initial begin
      logic [N-1:0] r;
      int w;
      bit quiet;

      reset        = 1'b1;
      bus.req      = '0;
      bus.done_fme = 1'b0;
      ultimo_m     = N - 1;
      #12;
      check_idle("in reset");
      step();
      reset = 1'b0;
      step();
      check_idle("after reset");

      bus.done_fme = 1'b1;
      repeat (3) step();
      check("done in LIVRE ocupado", bus.ocupado, 0);
      check("done in LIVRE concluido", bus.concluido, 0);
      bus.done_fme = 1'b0;

      run_job(4'b0001, 9, 1'b0, "single");
      for (int j = 0; j < 5; j++) run_job(4'b1111, 3, 1'b0, "all");

      run_job(4'b0010, 2, 1'b0, "sparse prep");
      run_job(4'b1001, 4, 1'b0, "sparse 3");
      run_job(4'b0001, 1, 1'b0, "sparse wrap");

      run_job(4'b0100, 5, 1'b1, "drop");
      repeat (3) begin
         step();
         check("drop no regrant", bus.gnt, 0);
      end

      run_job(4'b0110, FME_CICLOS_JOB, 1'b1, "nominal");

      // watchdog: done_fme never rises
      r = 4'b1000;
      w = pick(r);
      bus.req = r;
      step();
      check("wd gnt", bus.gnt, 32'd1 << w);
      step();
      check("wd enable", bus.enable_fme, 1);
      quiet = 1'b1;
      for (int i = 1; i < 127; i++) begin
         step();
         if (bus.reset_fme || bus.concluido || bus.erro_timeout || bus.gnt != r) quiet = 1'b0;
      end
      check("wd quiet before limit", quiet, 1);
`ifdef FME_ARB_TIMEOUT_EN
      step();
      check("wd reset_fme", bus.reset_fme, 1);
      check("wd erro", bus.erro_timeout, 1);
      check("wd concluido", bus.concluido, 1);
      check("wd concluido_id", bus.concluido_id, w);
      bus.req = '0;
      step();
      check("wd gnt clear", bus.gnt, 0);
      check("wd reset_fme width", bus.reset_fme, 0);
      check("wd erro width", bus.erro_timeout, 0);
      ultimo_m = w;
`else
      quiet = 1'b1;
      repeat (80) begin
         step();
         if (bus.reset_fme || bus.concluido || bus.erro_timeout || bus.gnt != r) quiet = 1'b0;
      end
      check("no wd gnt held", quiet, 1);
      bus.req = '0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      ultimo_m = N - 1;
`endif

      // async reset while in SAIDA
      bus.req = 4'b0010;
      step();
      check("rst gnt", bus.gnt, 4'b0010);
      step();
      step();
      bus.done_fme = 1'b1;
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      check_idle("async reset");
      bus.done_fme = 1'b0;
      step();
      reset = 1'b0;
      ultimo_m = N - 1;
      run_job(4'b0011, 3, 1'b0, "post reset");

      for (int j = 0; j < 20; j++) begin
         r = N'($urandom_range(1, (1 << N) - 1));
         run_job(r, $urandom_range(1, 12), 1'($urandom_range(0, 1)), "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global time limit observed=expired expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/fme_arbitro.md
Name: fme_arbitro

Overview:
- Round-robin arbiter/scheduler that shares one FME interpolator (its controller plus datapath) among N_REQ requesters, e.g. parallel motion-estimation candidate units.
- Grants one requester at a time and pulses `enable_fme` to start the interpolation controller.
- Tracks the controller's `done` window to detect job completion, then returns a completion pulse tagged with the requester ID.
- Sits between the requesters and the FME controller.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of requester ID.
- TIMEOUT_CICLOS, 127, max cycles from start pulse to job end before abort (nominal job is 43 cycles).
- CNT_W, $clog2(TIMEOUT_CICLOS+1), watchdog counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until own `concluido`.
- gnt  out  N_REQ  one-hot grant, held for the whole job.
- id_ativo  out  ID_W  index of the granted requester (valid while `ocupado`).
- ocupado  out  1  interpolator allocated.
- enable_fme  out  1  1-cycle start pulse to the FME controller `enable`.
- done_fme  in  1  controller `done`; high during post-interpolation drain.
- reset_fme  out  1  1-cycle abort pulse to the controller reset (watchdog).
- concluido  out  1  1-cycle job-complete pulse.
- concluido_id  out  ID_W  ID for `concluido`, valid with the pulse.
- erro_timeout  out  1  1-cycle pulse with `concluido` when the job was aborted.

Behaviour:
- Reset values (async): all outputs 0; state LIVRE; pointer `ultimo` = N_REQ-1, so requester 0 has first priority; watchdog = 0.
- All outputs are registered. No combinational path from `req` or `done_fme` to any output.
- State LIVRE:
  - If any `req` bit is set, pick the first set bit searching from (`ultimo`+1) mod N_REQ upward with wrap.
  - Register `gnt`/`id_ativo`, set `ocupado`=1, and go to DISPARO.
  - If no `req` bit is set, stay in LIVRE.
- State DISPARO (1 cycle): `enable_fme`=1, watchdog cleared, go to AGUARDA_DONE.
- State AGUARDA_DONE: when `done_fme`=1, go to SAIDA.
- State SAIDA: when `done_fme`=0 (falling edge; the controller is back in idle), go to CONCLUI.
- State CONCLUI (1 cycle):
  - `concluido`=1 and `concluido_id`=`id_ativo`.
  - Clear `gnt` and `ocupado`, set `ultimo`=`id_ativo`, go to LIVRE.
- Latency:
  - `req` to `gnt`: 1 cycle.
  - `gnt` to `enable_fme`: 1 cycle.
  - `done_fme` fall to `concluido`: 1 cycle.
  - Next grant can appear the cycle after CONCLUI.
- Watchdog: increments every cycle in AGUARDA_DONE and SAIDA.
- Requester drops `req` mid-job: ignored. The job completes and `concluido` still pulses for that ID.
- Granted requester's `req` still high after `concluido`: treated as a new request, with lowest priority under round-robin.
- `done_fme` high in LIVRE or DISPARO: ignored.
- `done_fme` already low when entering SAIDA: CONCLUI on the next cycle.
- Simultaneous timeout and `done_fme` falling edge: normal completion wins and no error is flagged.
- Reset mid-job: the arbiter returns immediately to its reset state and drives no `reset_fme`. The system reset also resets the controller.

Optional Feature:
- Macro: FME_ARB_TIMEOUT_EN.
- Defined: when the watchdog reaches TIMEOUT_CICLOS in AGUARDA_DONE or SAIDA:
  - Pulse `reset_fme`=1 for 1 cycle and go to CONCLUI.
  - In CONCLUI, `erro_timeout`=1 together with `concluido`.
- Undefined:
  - No watchdog counter; the arbiter waits indefinitely.
  - `reset_fme` and `erro_timeout` are tied to 0.

Decomposition:
- Shared package `fme_pkg`:
  - State encoding (LIVRE=0, DISPARO=1, AGUARDA_DONE=2, SAIDA=3, CONCLUI=4; 3 bits).
  - Nominal job length constant FME_CICLOS_JOB=43.
  - Default TIMEOUT_CICLOS.
- One natural sub-module: `fme_rr_seletor`, purely combinational.
  - Inputs: `req` and `ultimo`.
  - Outputs: one-hot winner, winner index, and `algum`.
- The FSM, registers and watchdog stay in `fme_arbitro`.

Test Plan:
- Single request: `req`=0001 → `gnt`=0001 one cycle later and `enable_fme` pulse the next cycle. Model `done_fme` high for 9 cycles → `concluido`=1 with `concluido_id`=0 one cycle after the fall.
- All requesters active: `req`=1111 held → grant order 0,1,2,3,0; each grant's `enable_fme` follows exactly 1 cycle after the grant.
- Sparse round-robin: `ultimo`=1, `req`=1001 → grant requester 3; then with `req`=0001 → grant requester 0 (wrap).
- Early drop: `req`=0100 granted, then `req` dropped to 0 during AGUARDA_DONE → job finishes and `concluido_id`=2; no new grant follows.
- Watchdog (macro defined): `done_fme` never rises → `reset_fme` and `erro_timeout` pulse exactly 127 cycles after `enable_fme`, and `gnt` clears. Same stimulus with the macro undefined → `gnt` stays held and `erro_timeout`=0.
- Async reset while in SAIDA with `gnt`=0010 → all outputs 0 immediately. After release with `req`=0011 → requester 0 is granted.
